ins_dispatch: RTL and testbench
===============================

Name: ins_dispatch

Overview:
- Buffers 16-bit instruction words from an upstream source and routes each 12-bit payload, in order, to one of four execution channels chosen by ins[13:12].
- Every channel has a one-entry output register with a valid/ready handshake.
- ins[15] requests a broadcast to all four channels.
- Sits between the instruction source and the four 12-bit consumer ports that the combinational channel decoder currently drives directly; it adds buffering, backpressure and stall accounting.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  instruction word offered.
- in_ready  out  1  FIFO can accept a word.
- in_ins  in  16  [15]=broadcast, [14]=reserved (ignored), [13:12]=channel select, [11:0]=payload.
- flush  in  1  synchronous clear of FIFO contents.
- ch_valid  out  4  bit k high: channel k register holds a payload.
- ch_ready  in  4  bit k high: channel k consumes its payload this cycle.
- ch_data  out  48  channel k payload at [12k+11:12k]; all zeros while ch_valid[k]=0.
- level  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- stall_cnt  out  CNT_W  saturating count of blocked-head cycles.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, level=0, ch_valid=0, ch_data=0, stall_cnt=0, in_ready=0 while held in reset. in_ready=1 from the first edge after release.
- in_ready = (level < DEPTH). It is registered state only, with no combinational path from ch_ready. Push occurs when in_valid & in_ready.
- Channel k is free when ch_valid[k]=0 or ch_ready[k]=1, so drain and refill in the same cycle gives full throughput.
- Dispatch (pop head) requires a non-empty FIFO and one of:
  - head[15]=0 and the channel selected by head[13:12] is free;
  - head[15]=1 and all four channels are free.
- On dispatch, the selected register(s) load head[11:0] and set ch_valid at the same edge.
- A channel that drains without a refill clears ch_valid[k] and zeroes its data.
- Strict in-order dispatch: a blocked head stalls every later word (head-of-line blocking is intended).
- Latency: a word pushed at edge N dispatches no earlier than edge N+1. ch_valid is therefore visible at the earliest one cycle after the accepting cycle.
- Throughput: one dispatch per cycle.
- Push and pop in the same cycle leave level unchanged. A push while full is impossible because in_ready=0.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- flush=1: FIFO emptied at the edge and level=0.
  - Any push or dispatch in that cycle is discarded.
  - Channel registers and stall_cnt are unaffected.
  - in_ready stays per level rule (so 1 the next cycle).
- stall_cnt increments on every cycle with level>0, no dispatch, and flush=0. It saturates at all-ones and never wraps. It is cleared only by reset.
- ch_ready[k] while ch_valid[k]=0 has no effect.
- Reset asserted mid-operation: all state cleared immediately. In-flight words are lost and no partial channel update is permitted.

Decomposition:
- Shared package ins_pkg holds:
  - NUM_CH=4, PAYLOAD_W=12, INS_W=16;
  - field constants SEL_LSB=12, SEL_W=2, BCAST_BIT=15;
  - a typedef for the 12-bit payload.
- Sub-module ins_fifo: synchronous FIFO with DEPTH, flush and level output, async active-low reset.
- Dispatch logic and channel registers live in ins_dispatch.

Test Plan:
- Single route:
  - Stimulus: push 16'h2ABC with ch_ready=4'b0000.
  - Response: ch_valid=4'b0100, ch_data[35:24]=12'hABC, other slices 0.
  - Then ch_ready[2]=1 for one cycle -> ch_valid=0, slice zeroed.
- Backpressure:
  - Stimulus: ch_ready=0, push 1 word to channel 0, then 4 more words to channel 0 (DEPTH=4).
  - Response: FIFO ends full -> in_ready=0, level=4.
  - stall_cnt increments once per cycle while the head is blocked on the occupied channel 0.
- Full throughput:
  - Stimulus: ch_ready=4'b1111, push 8 back-to-back words to channels 0,1,2,3,0,1,2,3.
  - Response: one dispatch per cycle, order preserved, in_ready never drops, stall_cnt stays 0.
- Broadcast block:
  - Stimulus: channel 1 occupied with ch_ready[1]=0, then push 16'h8123.
  - Response: broadcast waits; it dispatches when ch_ready[1]=1.
  - After dispatch: all four slices=12'h123 and ch_valid=4'b1111.
- Flush:
  - Stimulus: 3 words queued behind a blocked channel, then assert flush for one cycle.
  - Response: level=0, channel register retains its payload, stall_cnt holds its value.
- Reset mid-stream:
  - Stimulus: drop rst_n asynchronously (between edges) with level=3 and ch_valid=4'b0011.
  - Response: all outputs 0 immediately.
  - After release: in_ready=1 from the first edge and no stale dispatch occurs.

Source files
------------

// File: rtl/ins_pkg.sv
// Shared constants and types for the instruction dispatcher: word layout,
// channel count and the payload type carried to each execution channel.
package ins_pkg;

  localparam int NUM_CH    = 4;
  localparam int PAYLOAD_W = 12;
  localparam int INS_W     = 16;

  localparam int SEL_LSB   = 12;
  localparam int SEL_W     = 2;
  localparam int BCAST_BIT = 15;

  typedef logic [PAYLOAD_W-1:0] payload_t;

endpackage : ins_pkg

// File: rtl/ins_dispatch_if.sv
// Upstream instruction handshake plus the four downstream channel handshakes.
// slave = the dispatcher, master = the environment driving it.
interface ins_dispatch_if;
  import ins_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [INS_W-1:0]              in_ins;
  logic [NUM_CH-1:0]             ch_valid;
  logic [NUM_CH-1:0]             ch_ready;
  logic [NUM_CH*PAYLOAD_W-1:0]   ch_data;

  modport slave (
    input  in_valid, in_ins, ch_ready,
    output in_ready, ch_valid, ch_data
  );

  modport master (
    output in_valid, in_ins, ch_ready,
    input  in_ready, ch_valid, ch_data
  );

endinterface : ins_dispatch_if

// File: rtl/ins_fifo.sv
// Synchronous instruction FIFO with flush. Occupancy is tracked explicitly so
// full/empty never depend on pointer equality; ready is a registered flag.
module ins_fifo
  import ins_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [INS_W-1:0]             wdata_i,
  output logic                         ready_o,
  input  logic                         pop_i,
  output logic [INS_W-1:0]             rdata_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [INS_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q;
  logic             do_push;
  logic             do_pop;

  // A flush cycle swallows whatever push or pop coincides with it.
  assign do_push = push_i & ready_q & ~flush_i;
  assign do_pop  = pop_i & (level_q != '0) & ~flush_i;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ready_q <= (level_d < FULL_LVL);
    end
  end

  // NOTE: storage is deliberately not reset; level gates every read, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign ready_o = ready_q;

endmodule : ins_fifo

// File: rtl/ins_dispatch.sv
// In-order instruction dispatcher: FIFO head is routed to one channel (or all
// four for broadcast) once the target register(s) are free; blocked cycles are counted.
module ins_dispatch
  import ins_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ins_dispatch_if.slave                bus,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic [INS_W-1:0]              head;
  logic                          fifo_empty;
  logic                          dispatch;
  logic                          head_bcast;
  logic [SEL_W-1:0]              head_sel;
  payload_t                      head_payload;
  logic [NUM_CH-1:0]             ch_free;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0]             valid_q, valid_d;
  payload_t [NUM_CH-1:0]         data_q, data_d;
  logic [CNT_W-1:0]              stall_q, stall_d;

  ins_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (bus.in_valid),
    .wdata_i (bus.in_ins),
    .ready_o (bus.in_ready),
    .pop_i   (dispatch),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign head_bcast   = head[BCAST_BIT];
  assign head_sel     = head[SEL_LSB +: SEL_W];
  assign head_payload = head[PAYLOAD_W-1:0];

  always_comb begin
    ch_free  = ~valid_q | bus.ch_ready;
    load     = '0;
    valid_d  = valid_q;
    data_d   = data_q;
    stall_d  = stall_q;

    // Broadcast needs every register free at once; otherwise the head waits.
    if (!fifo_empty && !flush) begin
      if (head_bcast) begin
        if (&ch_free) load = '1;
      end else if (ch_free[head_sel]) begin
        load[head_sel] = 1'b1;
      end
    end
    dispatch = |load;

    for (int k = 0; k < NUM_CH; k++) begin
      if (load[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = head_payload;
      end else if (bus.ch_ready[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end
    end

    if (!fifo_empty && !dispatch && !flush && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign bus.ch_valid = valid_q;
  assign bus.ch_data  = data_q;
  assign stall_cnt    = stall_q;

endmodule : ins_dispatch

// File: tb/tb_ins_dispatch.sv
// Directed bench for ins_dispatch: stimulus pushes expected payloads per channel,
// a negedge monitor compares every channel handshake against those queues.
module tb_ins_dispatch;
  import ins_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                         clk;
  logic                         rst_n;
  logic                         flush;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic [CNT_W-1:0]             stall_cnt;

  ins_dispatch_if bus ();

  ins_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ready_waits = 0;
  logic [PAYLOAD_W-1:0] exp_q [NUM_CH][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_ins   = w;
    @(negedge clk);
    if (!bus.in_ready) ready_waits++;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready got 0 expected 1 for word %h", w);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (w[15]) begin
        for (int k = 0; k < NUM_CH; k++) exp_q[k].push_back(w[11:0]);
      end else begin
        exp_q[w[13:12]].push_back(w[11:0]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: consumption compares against queued payloads,
  // idle channels must present zero data.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_valid[k] && bus.ch_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ch%0d_unexpected: got %03h expected none", k, bus.ch_data[k*12 +: 12]);
          end else begin
            check($sformatf("ch%0d_data", k), 64'(bus.ch_data[k*12 +: 12]), 64'(exp_q[k].pop_front()));
          end
        end else if (!bus.ch_valid[k]) begin
          check($sformatf("ch%0d_idle_zero", k), 64'(bus.ch_data[k*12 +: 12]), 64'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ins   = '0;
    bus.ch_ready = '0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    check("rst_level",    64'(level),        64'h0);
    check("rst_ch_valid", 64'(bus.ch_valid), 64'h0);
    check("rst_ch_data",  64'(bus.ch_data),  64'h0);
    check("rst_stall",    64'(stall_cnt),    64'h0);
    #1 rst_n = 1'b1;
    step();
    check("rel_in_ready", 64'(bus.in_ready), 64'h1);

    // Single route
    push_word(16'h2ABC);
    check("route_pre_valid", 64'(bus.ch_valid), 64'h0);
    step();
    check("route_valid", 64'(bus.ch_valid), 64'h4);
    check("route_data",  64'(bus.ch_data),  64'h0000_0ABC_0000_00);
    bus.ch_ready = 4'b0100;
    step();
    bus.ch_ready = 4'b0000;
    check("route_drain_valid", 64'(bus.ch_valid), 64'h0);
    check("route_drain_data",  64'(bus.ch_data),  64'h0);
    check("route_stall",       64'(stall_cnt),    64'h0);

    // Backpressure on channel 0
    push_word(16'h0001);
    push_word(16'h0002);
    push_word(16'h0003);
    push_word(16'h0004);
    push_word(16'h0005);
    check("bp_level",    64'(level),        64'h4);
    check("bp_in_ready", 64'(bus.in_ready), 64'h0);
    check("bp_stall3",   64'(stall_cnt),    64'h3);
    step();
    step();
    check("bp_stall5",   64'(stall_cnt),    64'h5);
    bus.ch_ready = 4'b0001;
    repeat (7) step();
    bus.ch_ready = 4'b0000;
    check("bp_drain_level", 64'(level),        64'h0);
    check("bp_drain_valid", 64'(bus.ch_valid), 64'h0);
    check("bp_drain_stall", 64'(stall_cnt),    64'h5);

    // Full throughput
    ready_waits  = 0;
    bus.ch_ready = 4'b1111;
    push_word(16'h0101);
    push_word(16'h1102);
    push_word(16'h2103);
    push_word(16'h3104);
    push_word(16'h0105);
    push_word(16'h1106);
    push_word(16'h2107);
    push_word(16'h3108);
    check("tp_level1",      64'(level),       64'h1);
    check("tp_ready_waits", 64'(ready_waits), 64'h0);
    step();
    check("tp_level0",      64'(level),       64'h0);
    repeat (2) step();
    bus.ch_ready = 4'b0000;
    check("tp_valid", 64'(bus.ch_valid), 64'h0);
    check("tp_stall", 64'(stall_cnt),    64'h5);

    // Broadcast blocked by channel 1
    push_word(16'h1055);
    push_word(16'h8123);
    repeat (3) step();
    check("bc_wait_valid", 64'(bus.ch_valid), 64'h2);
    check("bc_wait_level", 64'(level),        64'h1);
    check("bc_wait_stall", 64'(stall_cnt),    64'h8);
    bus.ch_ready = 4'b0010;
    step();
    bus.ch_ready = 4'b0000;
    check("bc_valid", 64'(bus.ch_valid), 64'hF);
    check("bc_data",  64'(bus.ch_data),  64'h1231_2312_3123);
    check("bc_level", 64'(level),        64'h0);
    check("bc_stall", 64'(stall_cnt),    64'h8);
    bus.ch_ready = 4'b1111;
    step();
    bus.ch_ready = 4'b0000;
    check("bc_drain_valid", 64'(bus.ch_valid), 64'h0);

    // Flush behind a blocked channel
    push_word(16'h0AAA);
    push_word(16'h0BBB);
    push_word(16'h0CCC);
    push_word(16'h0DDD);
    check("fl_pre_level", 64'(level),     64'h3);
    check("fl_pre_stall", 64'(stall_cnt), 64'hA);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) void'(exp_q[0].pop_back());
    check("fl_level",    64'(level),        64'h0);
    check("fl_in_ready", 64'(bus.in_ready), 64'h1);
    check("fl_valid",    64'(bus.ch_valid), 64'h1);
    check("fl_data",     64'(bus.ch_data),  64'h0AAA);
    check("fl_stall",    64'(stall_cnt),    64'hA);
    step();
    check("fl_stall_hold", 64'(stall_cnt), 64'hA);
    bus.ch_ready = 4'b0001;
    step();
    bus.ch_ready = 4'b0000;
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("sb_empty_ch%0d", k), 64'(exp_q[k].size()), 64'h0);

    // Reset mid-stream
    push_word(16'h0011);
    push_word(16'h1022);
    push_word(16'h0033);
    push_word(16'h0044);
    push_word(16'h0055);
    check("mr_pre_level", 64'(level),        64'h3);
    check("mr_pre_valid", 64'(bus.ch_valid), 64'h3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_in_ready", 64'(bus.in_ready), 64'h0);
    check("mr_level",    64'(level),        64'h0);
    check("mr_valid",    64'(bus.ch_valid), 64'h0);
    check("mr_data",     64'(bus.ch_data),  64'h0);
    check("mr_stall",    64'(stall_cnt),    64'h0);
    for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    check("mr_rel_in_ready0", 64'(bus.in_ready), 64'h0);
    step();
    check("mr_rel_in_ready1", 64'(bus.in_ready), 64'h1);
    repeat (3) step();
    check("mr_rel_valid", 64'(bus.ch_valid), 64'h0);
    check("mr_rel_level", 64'(level),        64'h0);
    check("mr_rel_stall", 64'(stall_cnt),    64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ins_dispatch
